// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-flags,
// sticky overflow/underflow errors and a one-cycle read-valid strobe.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  WR,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  RD,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_ok, rd_ok;
    logic                  full, empty;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;
        if (EN) begin
            // A full FIFO still takes a write when a read frees a slot this cycle.
            wr_ok = WR && (!full || RD);
            rd_ok = RD && !empty;
            if (wr_ok) wptr_d = wptr_q + 1'b1;
            if (rd_ok) begin
                rptr_d   = rptr_q + 1'b1;
                dout_d   = mem[rptr_q];
                dvalid_d = 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (WR && full && !RD) ovf_d = 1'b1;
            if (RD && empty)       unf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_ok) mem[wptr_q] <= dataIn;
    end

    assign dataOut      = dout_q;
    assign dataValid    = dvalid_q;
    assign Count        = count_q;
    assign EMPTY        = empty;
    assign FULL         = full;
    assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));
    assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 4-bit x 8 FIFO buffer.
- Generalised data width and depth.
- Adds:
  - true simultaneous read/write
  - a full-range occupancy count (depth-deep FIFO reports FULL correctly)
  - programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - a read-valid strobe
- Sits between producer and consumer logic in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_LEVEL, 6, ALMOST_FULL asserts when Count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2, ALMOST_EMPTY asserts when Count <= AE_LEVEL. Legal range 0..DEPTH-1.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- EN  in  1  global enable; when 0, no read/write/flag update occurs (Rst still acts).
- WR  in  1  write request.
- dataIn  in  DATA_WIDTH  write data.
- RD  in  1  read request.
- dataOut  out  DATA_WIDTH  registered read data.
- dataValid  out  1  one-cycle pulse; dataOut holds a newly popped word.
- Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- EMPTY  out  1  Count==0.
- FULL  out  1  Count==DEPTH.
- ALMOST_EMPTY  out  1  Count<=AE_LEVEL.
- ALMOST_FULL  out  1  Count>=AF_LEVEL.
- OVERFLOW  out  1  sticky; a write was attempted while full and not accepted.
- UNDERFLOW  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (Rst=1 at posedge), regardless of EN:
  - read/write pointers = 0; Count = 0; dataOut = 0.
  - dataValid = 0; OVERFLOW = 0; UNDERFLOW = 0.
  - Resulting flags: EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL = (AF_LEVEL==0 ? 1 : 0).
  - Memory contents are not cleared.
- Status flags are combinational decodes of the registered Count. They are valid the cycle after the update.
- Accept rules (evaluated at posedge with EN=1, Rst=0):
  - wr_ok = WR & (!FULL | RD).
  - rd_ok = RD & !EMPTY.
- Write: when wr_ok, mem[wptr] <= dataIn and wptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Read: when rd_ok, dataOut <= mem[rptr], rptr increments modulo DEPTH, and dataValid=1 in the next cycle. Read latency is 1 clock.
- When no rd_ok: dataValid=0 and dataOut holds its last value.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - unchanged when both or neither.
- Simultaneous RD&WR:
  - Non-empty, non-full: both performed; Count unchanged.
  - Full: read performed and write accepted into the freed slot; Count stays DEPTH; OVERFLOW not set.
  - Empty: write only, no fall-through; UNDERFLOW set; dataValid=0.
- Error flags:
  - OVERFLOW <= 1 on WR & FULL & !RD.
  - UNDERFLOW <= 1 on RD & EMPTY.
  - Both hold until Rst. The rejected operation changes no pointer, memory or Count.
- EN=0: pointers, memory, Count, error flags and dataOut all hold; dataValid=0.
- Reset mid-operation: any RD/WR in the reset cycle is discarded. The first accepted write after reset lands in mem[0].
- No $stop or simulation-only control in the RTL. Wrap-around is normal operation.
- Synthesizable; memory inferred as a register array with one write port and one registered read port.

Test Plan:
(All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2.)
1. Reset then idle -> Count=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, dataOut=0.
2. Write 8'h10..8'h17 on 8 consecutive cycles:
   - FULL=1 and Count=8 after the 8th.
   - ALMOST_FULL=1 from Count=6.
   - A 9th write of 8'hFF sets OVERFLOW=1 and Count stays 8.
   - Draining then returns 8'h10..8'h17 in order, each with dataValid=1 one cycle after RD.
3. From empty, RD=1 -> UNDERFLOW=1, dataValid=0, Count=0. UNDERFLOW stays 1 through later valid traffic until Rst.
4. Fill to 8, then hold RD=WR=1 for 4 cycles with data 8'hA0..8'hA3:
   - Count stays 8; no OVERFLOW.
   - Popped words are 8'h10..8'h13.
   - A full drain yields 8'h14..8'h17 then 8'hA0..8'hA3, exercising pointer wrap.
5. Write 3 words, then EN=0 with RD=WR=1 for 5 cycles -> Count stays 3, no dataValid, no flag change. EN=1 resumes correctly.
6. Write 5 words, assert Rst with WR=1 -> Count=0, EMPTY=1. The next write 8'h5A is read back as 8'h5A.
